// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM encoding, special-case
// classification and the constant results returned for those cases.
package div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    SPEC_NONE,
    SPEC_DIV0,
    SPEC_OVF
  } special_e;

  typedef struct packed {
    logic quo_neg;
    logic rem_neg;
  } sign_t;

  // Constants are sized for the widest supported operand; users slice to WIDTH.
  localparam int unsigned MAX_WIDTH = 64;
  localparam logic [MAX_WIDTH-1:0] DIV0_QUOTIENT = '1;
  localparam logic [MAX_WIDTH-1:0] OVF_REMAINDER = '0;

endpackage

// File: rtl/div_core.sv
// Restoring divider datapath: one quotient bit per step, MSB first.
// The quotient register doubles as the dividend shift register.
module div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH+1:0] shifted;
  logic             fits;

  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    shifted = {rem_q, quo_q[WIDTH-1]};
    fits    = (shifted >= {2'b00, div_q});
    if (start_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      div_d = divisor_i;
      cnt_d = '0;
    end else if (step_i) begin
      rem_d = fits ? (WIDTH+1)'(shifted - {2'b00, div_q}) : shifted[WIDTH:0];
      quo_d = {quo_q[WIDTH-2:0], fits};
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  // Asserted while the final iteration is being performed, so the FSM can
  // leave CALC on the same edge that completes it.
  assign done_o      = (cnt_q == CNT_W'(WIDTH - 1));
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// Sequential signed/unsigned integer divider with valid/ready request and
// response handshakes; one operation in flight at a time.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_signed,
  input  logic             req_rem,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  localparam logic [WIDTH-1:0] SIGNED_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic             sel_rem_q, sel_rem_d;
  sign_t            neg_q, neg_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             rsp_valid_q, rsp_valid_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  special_e         special;
  logic             core_start, core_step, core_done;
  logic [WIDTH-1:0] core_quo, core_rem;
  logic [WIDTH-1:0] fix_quo, fix_rem;

  always_comb begin
    a_neg   = sgn_q & a_q[WIDTH-1];
    b_neg   = sgn_q & b_q[WIDTH-1];
    mag_a   = a_neg ? -a_q : a_q;
    mag_b   = b_neg ? -b_q : b_q;
    special = SPEC_NONE;
    if (b_q == '0) begin
      special = SPEC_DIV0;
    end else if (sgn_q && (a_q == SIGNED_MIN) && (b_q == '1)) begin
      special = SPEC_OVF;
    end
    fix_quo = neg_q.quo_neg ? -core_quo : core_quo;
    fix_rem = neg_q.rem_neg ? -core_rem : core_rem;
  end

  div_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .start_i    (core_start),
    .step_i     (core_step),
    .dividend_i (mag_a),
    .divisor_i  (mag_b),
    .done_o     (core_done),
    .quotient_o (core_quo),
    .remainder_o(core_rem)
  );

  // A special-case result enters DONE with rsp_valid still low and is
  // published one cycle later, keeping its latency at two edges.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sgn_d       = sgn_q;
    sel_rem_d   = sel_rem_q;
    neg_d       = neg_q;
    result_d    = result_q;
    rsp_valid_d = rsp_valid_q;
    core_start  = 1'b0;
    core_step   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          a_d       = req_a;
          b_d       = req_b;
          sgn_d     = req_signed;
          sel_rem_d = req_rem;
          state_d   = ST_PREP;
        end
      end
      ST_PREP: begin
        neg_d.quo_neg = a_neg ^ b_neg;
        neg_d.rem_neg = a_neg;
        case (special)
          SPEC_DIV0: begin
            result_d = sel_rem_q ? a_q : DIV0_QUOTIENT[WIDTH-1:0];
            state_d  = ST_DONE;
          end
          SPEC_OVF: begin
            result_d = sel_rem_q ? OVF_REMAINDER[WIDTH-1:0] : a_q;
            state_d  = ST_DONE;
          end
          default: begin
            core_start = 1'b1;
            state_d    = ST_CALC;
          end
        endcase
      end
      ST_CALC: begin
        core_step = 1'b1;
        if (core_done) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        result_d    = sel_rem_q ? fix_rem : fix_quo;
        rsp_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sgn_q       <= 1'b0;
      sel_rem_q   <= 1'b0;
      neg_q       <= '0;
      result_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sgn_q       <= sgn_d;
      sel_rem_q   <= sel_rem_d;
      neg_q       <= neg_d;
      result_q    <= result_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_valid_q ? result_q : '0;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: directed and random divisions are scored
// against a plain-arithmetic model, including latency, backpressure and reset.
`timescale 1ns/1ps
module tb_div_seq;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_signed = 1'b0;
  logic             req_rem = 1'b0;
  logic             rsp_ready = 1'b1;
  logic [WIDTH-1:0] req_a = '0;
  logic [WIDTH-1:0] req_b = '0;
  logic             req_ready;
  logic             rsp_valid;
  logic             busy;
  logic [WIDTH-1:0] rsp_data;

  typedef struct {
    logic [31:0] data;
    longint      lat;
    longint      acc;
  } exp_t;

  exp_t   expQ[$];
  exp_t   monE;
  int     checkCount = 0;
  int     passCount = 0;
  longint cycle = 0;
  longint riseCycle = 0;
  bit     sawValid = 1'b0;
  bit     readyRandom = 1'b0;

  div_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_signed(req_signed),
    .req_rem   (req_rem),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: truncating division from native arithmetic plus the two special rules.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                input logic r, output logic [31:0] d, output longint lat);
    longint sa, sb, q, m;
    if (b == 32'd0) begin
      d   = r ? a : 32'hFFFF_FFFF;
      lat = 2;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      d   = r ? 32'd0 : a;
      lat = 2;
    end else begin
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      q   = sa / sb;
      m   = sa % sb;
      d   = r ? m[31:0] : q[31:0];
      lat = 34;
    end
  endfunction

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s, input logic r);
    logic [31:0] d;
    longint      lat;
    int          w;
    exp_t        e;
    w = 0;
    while (!req_ready && w < 300) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!req_ready) begin
      checkCount++;
      $display("[TB] FAIL req_ready_timeout: got 0, wanted 1");
      return;
    end
    req_a      = a;
    req_b      = b;
    req_signed = s;
    req_rem    = r;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    model(a, b, s, r, d, lat);
    e.data = d;
    e.lat  = lat;
    e.acc  = cycle;
    expQ.push_back(e);
  endtask

  task automatic waitDrain();
    int w;
    w = 0;
    while (expQ.size() != 0 && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    checkOutput("drain_queue_empty", 64'(expQ.size()), 64'd0);
  endtask

  // Monitor: scores each response at its handshake and tracks when rsp_valid rose.
  always @(negedge clk) begin
    if (rst) begin
      sawValid = 1'b0;
    end else begin
      if (!rsp_valid) checkOutput("data_zero_when_idle", 64'(rsp_data), 64'd0);
      if (rsp_valid && !sawValid) begin
        sawValid  = 1'b1;
        riseCycle = cycle;
      end
      if (rsp_valid && rsp_ready) begin
        if (expQ.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL unexpected_rsp: got data 0x%0h, wanted no response", rsp_data);
        end else begin
          monE = expQ.pop_front();
          checkOutput("rsp_data", 64'(rsp_data), 64'(monE.data));
          checkOutput("rsp_latency", riseCycle - monE.acc, monE.lat);
        end
        sawValid = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] dirA [12];
    logic [31:0] dirB [12];
    logic        dirS [12];
    logic        dirR [12];
    logic [31:0] ra, rb;
    int          w;

    fork
      forever begin
        @(posedge clk);
        #1;
        if (readyRandom) rsp_ready = ($urandom_range(0, 3) != 0);
      end
    join_none

    dirA = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h1234_5678, 32'h1234_5678,
             32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    dirB = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd0, 32'd0,
             32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    dirS = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    dirR = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_req_ready", 64'(req_ready), 64'd1);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_rsp_data", 64'(rsp_data), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(dirA[i], dirB[i], dirS[i], dirR[i]);
      if (i == 0) checkOutput("first_accept_busy", 64'(busy), 64'd1);
    end
    waitDrain();

    $display("[TB] backpressure phase");
    rsp_ready = 1'b0;
    applyStimulus(32'd100, 32'd7, 1'b0, 1'b0);
    w = 0;
    while (!rsp_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    checkOutput("bp_valid_rise", 64'(rsp_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_valid_held", 64'(rsp_valid), 64'd1);
      checkOutput("bp_data_held", 64'(rsp_data), 64'd14);
      checkOutput("bp_req_ready_low", 64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_hs_req_ready", 64'(req_ready), 64'd1);
    checkOutput("post_hs_valid_low", 64'(rsp_valid), 64'd0);

    $display("[TB] mid-operation reset phase");
    applyStimulus(32'hDEAD_BEEF, 32'd3, 1'b0, 1'b0);
    repeat (11) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_req_ready", 64'(req_ready), 64'd1);
    checkOutput("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("abort_rsp_data", 64'(rsp_data), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    expQ.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(32'd1000, 32'd10, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] random phase");
    readyRandom = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: rb = $urandom;
        3: begin
          ra = 32'h8000_0000;
          rb = 32'hFFFF_FFFF;
        end
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    readyRandom = 1'b0;
    @(posedge clk);
    #2;
    rsp_ready = 1'b1;
    waitDrain();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_a  input  WIDTH  dividend.
REQ-007 req_b  input  WIDTH  divisor.
REQ-008 req_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 req_rem  input  1  0 = return quotient, 1 = return remainder.
REQ-010 rsp_valid  output  1  result present.
REQ-011 rsp_ready  input  1  consumer takes the result.
REQ-012 rsp_data  output  WIDTH  quotient or remainder.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The block SHALL accept a request on a rising edge where req_valid && req_ready, latching req_a, req_b, req_signed and req_rem.
REQ-015 req_ready SHALL be high only in IDLE, so there is one operation in flight and no overlap.
REQ-016 The FSM SHALL have the states IDLE, PREP, CALC, FIX and DONE.
REQ-017 Transitions SHALL be:
- IDLE->PREP on accept.
- PREP->DONE on a special case; otherwise PREP->CALC.
- CALC->FIX after exactly WIDTH iterations.
- FIX->DONE.
- DONE->IDLE on rsp_valid && rsp_ready.
REQ-018 PREP SHALL form the operand magnitudes: absolute values when signed, raw values when unsigned.
REQ-019 PREP SHALL record the quotient sign (a[MSB]^b[MSB]) and the remainder sign (a[MSB]); both signs SHALL be 0 when unsigned.
REQ-020 Each CALC cycle SHALL perform one restoring iteration, MSB first:
- rem = {rem, next dividend bit}, using a WIDTH+1-bit remainder register.
- if rem >= |B|: rem -= |B| and the quotient bit = 1; otherwise the quotient bit = 0.
REQ-021 FIX SHALL two's-complement-negate the quotient and/or remainder per the recorded signs, then select the output per req_rem.
REQ-022 Divide by zero SHALL be a special case returning quotient = all ones and remainder = req_a, in both signed and unsigned mode.
REQ-023 Signed overflow (A = 0x8000_0000, B = 0xFFFF_FFFF, scaled to WIDTH) SHALL be a special case returning quotient = A and remainder = 0.
REQ-024 rsp_valid SHALL rise at the 34th rising edge after the accept edge (WIDTH+2) on the normal path, and at the 2nd edge on a special case.
REQ-025 While rsp_valid && !rsp_ready, rsp_data SHALL be held stable and rsp_valid SHALL stay high.
REQ-026 rsp_valid SHALL fall on the edge after the response handshake, and req_ready SHALL rise in that same cycle.
REQ-027 rsp_data SHALL be 0 whenever rsp_valid is low.
REQ-028 Signed results SHALL follow truncating division: the quotient rounds toward zero and the remainder takes the sign of the dividend.

Reset
REQ-029 Asserting rst SHALL asynchronously force state IDLE and clear all datapath registers, including mid-operation, with no response emitted for the aborted operation.
REQ-030 Reset values SHALL be: req_ready=1 (IDLE), rsp_valid=0, rsp_data=0, busy=0.
REQ-031 The first accept after rst deasserts SHALL be honoured on the first rising edge with req_valid high.

Structure
REQ-032 The FSM state encoding and the special-case result constants SHALL live in the shared package div_pkg.
REQ-033 The iteration datapath (remainder/quotient shift registers, compare-subtract, iteration counter) SHALL be the sub-module div_core.
REQ-034 div_core SHALL be controlled by start/step/done signals from the div_seq FSM.
REQ-035 The RTL SHALL contain no latches, no assign statements inside always blocks, and no multiple drivers of any register.

Verification
REQ-036 Unsigned 100/7: req_rem=0 -> rsp_data=14 at edge 34; req_rem=1 -> rsp_data=2.
REQ-037 Signed -7/2 (0xFFFFFFF9, 0x00000002): quotient -> 0xFFFFFFFD; remainder -> 0xFFFFFFFF.
REQ-038 Divide by zero, A=0x12345678, B=0: quotient -> 0xFFFFFFFF and remainder -> 0x12345678, each at edge 2.
REQ-039 A=0x80000000, B=0xFFFFFFFF:
- Signed: quotient -> 0x80000000, remainder -> 0 (edge 2).
- Unsigned: quotient -> 0, remainder -> 0x80000000 (edge 34).
REQ-040 Backpressure: rsp_ready held low 10 cycles -> rsp_valid and rsp_data stable and req_ready=0 throughout; after the handshake, req_ready=1 on the next cycle.
REQ-041 rst pulsed at CALC iteration 10 -> outputs return to reset values immediately; a following 1000/10 request returns 100.
